// File: rtl/reg_select_stage.sv
// reg_select_stage
//   Registered register-select stage between instruction fetch and
//   register-file read. Each accepted machine-code word is decoded by
//   operation class into source/destination register indices. The result
//   is held in a one-entry valid/ready output register. A per-register
//   pending-write scoreboard holds back any instruction whose source
//   register still has an outstanding write. Writeback completions clear
//   scoreboard entries, and a completion reported in the same cycle
//   releases the hazard at once.
//
// Ports
//   Clk, Reset        rising-edge clock, asynchronous active-high reset
//   in_valid/in_ready upstream handshake for mach_code/op_class
//   mach_code[IW]     instruction word
//   op_class[2]       00 regular, 01 add, 10 shift, 11 branch
//   wb_valid, wb_reg  register write completion from writeback
//   out_valid/out_ready downstream handshake
//   InRegA/B/W        decoded source A, source B, destination indices
//   has_dest          instruction writes InRegW
//   out_class         registered op_class
//   stall             hazard is blocking in_valid this cycle
//   stall_cnt[CW]     saturating count of stalled cycles
module reg_select_stage #(
  parameter int IW       = 9,
  parameter int RAW      = 4,
  parameter int FLAG_REG = 8,
  parameter int CW       = 16
) (
  input  logic           Clk,
  input  logic           Reset,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [IW-1:0]  mach_code,
  input  logic [1:0]     op_class,
  input  logic           wb_valid,
  input  logic [RAW-1:0] wb_reg,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [RAW-1:0] InRegA,
  output logic [RAW-1:0] InRegB,
  output logic [RAW-1:0] InRegW,
  output logic           has_dest,
  output logic [1:0]     out_class,
  output logic           stall,
  output logic [CW-1:0]  stall_cnt
);

  localparam int NREG = 2 ** RAW;

  typedef enum logic [1:0] {
    CLS_REGULAR = 2'b00,
    CLS_ADD     = 2'b01,
    CLS_SHIFT   = 2'b10,
    CLS_BRANCH  = 2'b11
  } op_class_e;

  // Upper instruction bits are not used by any decode rule.
  if (IW > 6) begin : g_hi_bits
    logic unused_hi;
    assign unused_hi = ^mach_code[IW-1:6];
  end

  logic [RAW-1:0]  dec_a;
  logic [RAW-1:0]  dec_b;
  logic [RAW-1:0]  dec_w;
  logic            dec_hd;
  logic            dec_use_b;

  logic [NREG-1:0] pending;
  logic [NREG-1:0] pending_next;
  logic [NREG-1:0] wb_mask;
  logic [NREG-1:0] pending_eff;
  logic            hazard;
  logic            accept;

  // Field decode; every index is zero-extended to RAW bits.
  always_comb begin
    dec_a     = '0;
    dec_b     = '0;
    dec_w     = '0;
    dec_hd    = 1'b0;
    dec_use_b = 1'b0;
    unique case (op_class_e'(op_class))
      CLS_REGULAR: begin
        dec_a     = RAW'(mach_code[5:3]);
        dec_b     = RAW'(mach_code[2:0]);
        dec_w     = RAW'(mach_code[5:3]);
        dec_hd    = 1'b1;
        dec_use_b = 1'b1;
      end
      CLS_ADD: begin
        dec_a  = RAW'(mach_code[5:2]);
        dec_b  = RAW'(mach_code[5:3]);
        dec_w  = RAW'(mach_code[5:2]);
        dec_hd = 1'b1;
      end
      CLS_SHIFT: begin
        dec_a  = RAW'(mach_code[3:1]);
        dec_b  = RAW'(mach_code[5:3]);
        dec_w  = RAW'(mach_code[3:1]);
        dec_hd = 1'b1;
      end
      CLS_BRANCH: begin
        dec_a     = RAW'(FLAG_REG);
        dec_b     = RAW'(mach_code[0]);
        dec_w     = '0;
        dec_hd    = 1'b0;
        dec_use_b = 1'b1;
      end
      default: ;
    endcase
  end

  // A writeback in this cycle masks its register out of the hazard check.
  assign wb_mask     = wb_valid ? (NREG'(1) << wb_reg) : '0;
  assign pending_eff = pending & ~wb_mask;

  assign hazard   = in_valid & (pending_eff[dec_a] | (dec_use_b & pending_eff[dec_b]));
  assign stall    = hazard;
  assign in_ready = ~Reset & ~hazard & (~out_valid | out_ready);
  assign accept   = in_valid & in_ready;

  // Clear is applied before set so a new writer wins over a same-cycle
  // completion of the same register.
  always_comb begin
    pending_next = pending & ~wb_mask;
    if (accept && dec_hd) begin
      pending_next[dec_w] = 1'b1;
    end
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      pending <= '0;
    end else begin
      pending <= pending_next;
    end
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      out_valid <= 1'b0;
      InRegA    <= '0;
      InRegB    <= '0;
      InRegW    <= '0;
      has_dest  <= 1'b0;
      out_class <= '0;
    end else if (accept) begin
      out_valid <= 1'b1;
      InRegA    <= dec_a;
      InRegB    <= dec_b;
      InRegW    <= dec_w;
      has_dest  <= dec_hd;
      out_class <= op_class;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      stall_cnt <= '0;
    end else if (hazard && (stall_cnt != '1)) begin
      stall_cnt <= stall_cnt + CW'(1);
    end
  end

endmodule

// File: tb/tb_reg_select_stage.sv
// Bench for reg_select_stage: directed vectors with literal expectations,
// plus a behavioural scoreboard model compared against the DUT every cycle.
module tb_reg_select_stage;

  localparam int IW      = 9;
  localparam int RAW     = 4;
  localparam int NREG    = 16;
  localparam int FLAG    = 8;
  localparam int CW      = 4;
  localparam int CNT_MAX = (1 << CW) - 1;

  logic           Clk = 1'b0;
  logic           Reset;
  logic           in_valid;
  logic           in_ready;
  logic [IW-1:0]  mach_code;
  logic [1:0]     op_class;
  logic           wb_valid;
  logic [RAW-1:0] wb_reg;
  logic           out_valid;
  logic           out_ready;
  logic [RAW-1:0] InRegA;
  logic [RAW-1:0] InRegB;
  logic [RAW-1:0] InRegW;
  logic           has_dest;
  logic [1:0]     out_class;
  logic           stall;
  logic [CW-1:0]  stall_cnt;

  int n_checks = 0;
  int n_fail   = 0;

  reg_select_stage #(
    .IW(IW),
    .RAW(RAW),
    .FLAG_REG(FLAG),
    .CW(CW)
  ) dut (
    .Clk(Clk),
    .Reset(Reset),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .mach_code(mach_code),
    .op_class(op_class),
    .wb_valid(wb_valid),
    .wb_reg(wb_reg),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .InRegA(InRegA),
    .InRegB(InRegB),
    .InRegW(InRegW),
    .has_dest(has_dest),
    .out_class(out_class),
    .stall(stall),
    .stall_cnt(stall_cnt)
  );

  always #5 Clk = ~Clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  bit pend[NREG];
  int m_cnt;
  bit m_ov;
  int m_a, m_b, m_w, m_cls;
  bit m_hd;

  function automatic void decode(input logic [8:0] code, input logic [1:0] cls,
                                 output int a, output int b, output int w,
                                 output bit hd, output int s0, output int s1);
    case (cls)
      2'd0: begin a = int'(code[5:3]); b = int'(code[2:0]); w = a; hd = 1; s0 = a; s1 = b;  end
      2'd1: begin a = int'(code[5:2]); b = int'(code[5:3]); w = a; hd = 1; s0 = a; s1 = -1; end
      2'd2: begin a = int'(code[3:1]); b = int'(code[5:3]); w = a; hd = 1; s0 = a; s1 = -1; end
      default: begin a = FLAG; b = int'(code[0]); w = 0; hd = 0; s0 = a; s1 = b; end
    endcase
  endfunction

  function automatic bit busy(input int r);
    if (r < 0) return 0;
    return pend[r] && !(wb_valid && int'(wb_reg) == r);
  endfunction

  function automatic bit model_hazard();
    int a, b, w, s0, s1;
    bit hd;
    decode(mach_code, op_class, a, b, w, hd, s0, s1);
    return in_valid && (busy(s0) || busy(s1));
  endfunction

  task automatic model_clear();
    foreach (pend[i]) pend[i] = 0;
    m_cnt = 0; m_ov = 0; m_a = 0; m_b = 0; m_w = 0; m_hd = 0; m_cls = 0;
  endtask

  task automatic model_step();
    int a, b, w, s0, s1;
    bit hd, hz, rdy;
    decode(mach_code, op_class, a, b, w, hd, s0, s1);
    hz  = model_hazard();
    rdy = !hz && (!m_ov || out_ready);
    if (hz && m_cnt < CNT_MAX) m_cnt++;
    if (wb_valid) pend[int'(wb_reg)] = 0;
    if (in_valid && rdy) begin
      if (hd) pend[w] = 1;
      m_ov = 1; m_a = a; m_b = b; m_w = w; m_hd = hd; m_cls = int'(op_class);
    end else if (m_ov && out_ready) begin
      m_ov = 0;
    end
  endtask

  initial begin
    model_clear();
    forever begin
      @(negedge Clk);
      if (Reset) model_clear();
      check("m_stall",     32'(stall),     32'(model_hazard()));
      check("m_in_ready",  32'(in_ready),  32'(!Reset && !model_hazard() && (!m_ov || out_ready)));
      check("m_out_valid", 32'(out_valid), 32'(m_ov));
      check("m_InRegA",    32'(InRegA),    m_a);
      check("m_InRegB",    32'(InRegB),    m_b);
      check("m_InRegW",    32'(InRegW),    m_w);
      check("m_has_dest",  32'(has_dest),  32'(m_hd));
      check("m_out_class", 32'(out_class), m_cls);
      check("m_stall_cnt", 32'(stall_cnt), m_cnt);
      @(posedge Clk);
      if (Reset) model_clear();
      else model_step();
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic tick(input int n = 1);
    repeat (n) @(posedge Clk);
    #1;
  endtask

  task automatic set_in(input logic v, input logic [8:0] code, input logic [1:0] cls);
    in_valid  = v;
    mach_code = code;
    op_class  = cls;
  endtask

  task automatic wb(input logic v, input logic [3:0] r);
    wb_valid = v;
    wb_reg   = r;
  endtask

  initial begin
    Reset = 1'b1;
    set_in(1'b0, '0, 2'd0);
    wb(1'b0, 4'd0);
    out_ready = 1'b1;
    tick(2);
    check("rst_out_valid", 32'(out_valid), 0);
    check("rst_stall_cnt", 32'(stall_cnt), 0);
    check("rst_in_ready",  32'(in_ready),  0);
    Reset = 1'b0;
    #1;
    check("post_rst_in_ready", 32'(in_ready), 1);

    // decode of each class
    set_in(1'b1, 9'b000_101_011, 2'd0); tick();
    check("reg_A", 32'(InRegA), 5);
    check("reg_B", 32'(InRegB), 3);
    check("reg_W", 32'(InRegW), 5);
    check("reg_hd", 32'(has_dest), 1);
    set_in(1'b1, 9'b000_1011_00, 2'd1); tick();
    check("add_A", 32'(InRegA), 11);
    set_in(1'b1, 9'b000_000_110, 2'd2); tick();
    check("shift_A", 32'(InRegA), 3);
    set_in(1'b1, 9'b000_000_001, 2'd3); tick();
    check("br_A", 32'(InRegA), 8);
    check("br_B", 32'(InRegB), 1);
    check("br_W", 32'(InRegW), 0);
    check("br_hd", 32'(has_dest), 0);
    in_valid = 1'b0;
    wb(1'b1, 4'd5); tick();
    wb(1'b1, 4'd11); tick();
    wb(1'b1, 4'd3); tick();
    wb(1'b0, 4'd0);

    // RAW hazard on r5, released by same-cycle writeback
    set_in(1'b1, 9'b000_101_000, 2'd0); tick();
    set_in(1'b1, 9'b000_0101_00, 2'd1);
    repeat (3) begin
      #1;
      check("raw_stall", 32'(stall), 1);
      check("raw_in_ready", 32'(in_ready), 0);
      tick();
    end
    check("raw_stall_cnt", 32'(stall_cnt), 3);
    wb(1'b1, 4'd5);
    #1;
    check("bypass_stall", 32'(stall), 0);
    check("bypass_in_ready", 32'(in_ready), 1);
    tick();
    wb(1'b0, 4'd0);
    in_valid = 1'b0;
    check("bypass_A", 32'(InRegA), 5);
    check("bypass_cls", 32'(out_class), 1);
    wb(1'b1, 4'd5); tick();
    wb(1'b0, 4'd0);

    // backpressure hold, then back-to-back issue
    out_ready = 1'b0;
    set_in(1'b1, 9'b000_001_010, 2'd0); tick();
    set_in(1'b1, 9'b000_011_100, 2'd0);
    repeat (4) begin
      #1;
      check("hold_in_ready", 32'(in_ready), 0);
      check("hold_stall", 32'(stall), 0);
      check("hold_A", 32'(InRegA), 1);
      check("hold_B", 32'(InRegB), 2);
      tick();
    end
    out_ready = 1'b1;
    #1;
    check("release_in_ready", 32'(in_ready), 1);
    tick();
    set_in(1'b1, 9'b000_110_111, 2'd0);
    check("b2b_A_y", 32'(InRegA), 3);
    tick();
    in_valid = 1'b0;
    check("b2b_A_z", 32'(InRegA), 6);
    check("b2b_valid", 32'(out_valid), 1);
    tick();
    check("drain_valid", 32'(out_valid), 0);

    // set wins over same-cycle clear of r2
    set_in(1'b1, 9'b000_010_000, 2'd0); tick();
    wb(1'b1, 4'd2);
    #1;
    check("setwin_in_ready", 32'(in_ready), 1);
    tick();
    wb(1'b0, 4'd0);
    set_in(1'b1, 9'b000_000_100, 2'd2);
    #1;
    check("setwin_stall", 32'(stall), 1);
    check("setwin_in_ready_rd", 32'(in_ready), 0);
    tick();

    // reset while stalled
    #2;
    Reset = 1'b1;
    #1;
    check("midrst_valid", 32'(out_valid), 0);
    check("midrst_A", 32'(InRegA), 0);
    check("midrst_cnt", 32'(stall_cnt), 0);
    check("midrst_in_ready", 32'(in_ready), 0);
    tick();
    Reset = 1'b0;
    #1;
    check("after_rst_in_ready", 32'(in_ready), 1);
    check("after_rst_stall", 32'(stall), 0);
    check("after_rst_valid", 32'(out_valid), 0);
    in_valid = 1'b0;
    tick();

    // stall counter saturation
    set_in(1'b1, 9'b000_100_000, 2'd0); tick();
    set_in(1'b1, 9'b000_000_100, 2'd0);
    tick(20);
    check("sat_cnt", 32'(stall_cnt), 15);
    check("sat_stall", 32'(stall), 1);
    in_valid = 1'b0;
    wb(1'b1, 4'd4); tick();
    wb(1'b0, 4'd0);
    tick(2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
